// File: rtl/mcu_apb_pkg.sv
// Shared types and constants for the 8051 EMIF to APB bridge.
package mcu_apb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SETUP    = 3'd1,
        ST_ACCESS   = 3'd2,
        ST_ACK      = 3'd3,
        ST_WAIT_REL = 3'd4
    } state_e;

    localparam logic [1:0] LANE0 = 2'd0;
    localparam logic [1:0] LANE1 = 2'd1;
    localparam logic [1:0] LANE2 = 2'd2;
    localparam logic [1:0] LANE3 = 2'd3;

    localparam int TO_MAX_DEF = 255;

endpackage

// File: rtl/mcu_apb_bridge.sv
// 8051 byte-bus to 32-bit APB master bridge: byte writes gather in a shadow and
// issue on lane 3; lane-0 reads fetch a word, lanes 1-3 are served from the read shadow.
module mcu_apb_bridge
    import mcu_apb_pkg::*;
#(
    parameter int ADDR_W = 20,
    parameter int TO_MAX = TO_MAX_DEF,
    parameter int TO_W   = 8
) (
    input  logic              cpuclk,
    input  logic              rst,
    input  logic [22:0]       memaddr,
    input  logic [7:0]        memdatao,
    input  logic              memrd,
    input  logic              memwr,
    output logic              memack,
    output logic [7:0]        memdatai,
    input  logic              err_clr,
    output logic              timeout_err,
    output logic [ADDR_W-1:0] paddr,
    output logic              pwrite,
    output logic [31:0]       pwdata,
    output logic              psel,
    output logic              penable,
    input  logic [31:0]       prdata,
    input  logic              pready
);

    state_e              state_q;
    logic                memack_q;
    logic [7:0]          memdatai_q;
    logic                timeout_err_q;
    logic [ADDR_W-1:0]   paddr_q;
    logic                pwrite_q;
    logic [31:0]         pwdata_q;
    logic                psel_q;
    logic                penable_q;
    logic [23:0]         wshadow_q;
    logic [23:0]         wshadow_d;
    logic [31:0]         rshadow_q;
    logic [7:0]          rbyte_d;
    logic [TO_W-1:0]     count_q;
    logic [ADDR_W-1:0]   paddr_d;
    logic [1:0]          lane;
    logic                unused_addr;

    assign lane        = memaddr[1:0];
    assign paddr_d     = {{(ADDR_W-11){1'b0}}, memaddr[10:2], 2'b00};
    assign unused_addr = ^memaddr[22:11];

    // Byte 3 never lands in the write shadow; it goes straight into pwdata.
    always_comb begin
        wshadow_d = wshadow_q;
        case (lane)
            LANE0:   wshadow_d[7:0]   = memdatao;
            LANE1:   wshadow_d[15:8]  = memdatao;
            LANE2:   wshadow_d[23:16] = memdatao;
            default: wshadow_d        = wshadow_q;
        endcase
    end

    always_comb begin
        rbyte_d = rshadow_q[7:0];
        case (lane)
            LANE1:   rbyte_d = rshadow_q[15:8];
            LANE2:   rbyte_d = rshadow_q[23:16];
            LANE3:   rbyte_d = rshadow_q[31:24];
            default: rbyte_d = rshadow_q[7:0];
        endcase
    end

    always_ff @(posedge cpuclk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            memack_q      <= 1'b0;
            memdatai_q    <= 8'h00;
            timeout_err_q <= 1'b0;
            paddr_q       <= '0;
            pwrite_q      <= 1'b0;
            pwdata_q      <= 32'h0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            wshadow_q     <= 24'h0;
            rshadow_q     <= 32'h0;
            count_q       <= '0;
        end else begin
            // A timeout later in this block overrides the clear.
            if (err_clr) timeout_err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (memwr) begin
                        if (lane == LANE3) begin
                            pwdata_q <= {memdatao, wshadow_q};
                            pwrite_q <= 1'b1;
                            paddr_q  <= paddr_d;
                            psel_q   <= 1'b1;
                            state_q  <= ST_SETUP;
                        end else begin
                            wshadow_q <= wshadow_d;
                            memack_q  <= 1'b1;
                            state_q   <= ST_ACK;
                        end
                    end else if (memrd) begin
                        if (lane == LANE0) begin
                            pwrite_q <= 1'b0;
                            paddr_q  <= paddr_d;
                            psel_q   <= 1'b1;
                            state_q  <= ST_SETUP;
                        end else begin
                            memdatai_q <= rbyte_d;
                            memack_q   <= 1'b1;
                            state_q    <= ST_ACK;
                        end
                    end
                end
                ST_SETUP: begin
                    penable_q <= 1'b1;
                    count_q   <= '0;
                    state_q   <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (pready) begin
                        if (!pwrite_q) begin
                            rshadow_q  <= prdata;
                            memdatai_q <= prdata[7:0];
                        end
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                        memack_q  <= 1'b1;
                        state_q   <= ST_ACK;
                    end else if (count_q == TO_W'(TO_MAX)) begin
                        timeout_err_q <= 1'b1;
                        if (!pwrite_q) begin
                            rshadow_q  <= 32'hFFFF_FFFF;
                            memdatai_q <= 8'hFF;
                        end
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                        memack_q  <= 1'b1;
                        state_q   <= ST_ACK;
                    end else begin
                        count_q <= count_q + 1'b1;
                    end
                end
                ST_ACK: begin
                    memack_q <= 1'b0;
                    state_q  <= ST_WAIT_REL;
                end
                ST_WAIT_REL: begin
                    if (!memrd && !memwr) state_q <= ST_IDLE;
                end
                default: begin
                    psel_q    <= 1'b0;
                    penable_q <= 1'b0;
                    memack_q  <= 1'b0;
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

    assign memack      = memack_q;
    assign memdatai    = memdatai_q;
    assign timeout_err = timeout_err_q;
    assign paddr       = paddr_q;
    assign pwrite      = pwrite_q;
    assign pwdata      = pwdata_q;
    assign psel        = psel_q;
    assign penable     = penable_q;

endmodule

// File: tb/tb_mcu_apb_bridge.sv
// Directed bench for mcu_apb_bridge: table of MCU transactions plus hand-written timeout/reset sequences.
module tb_mcu_apb_bridge;

    localparam int BUDGET = 300;

    logic        cpuclk;
    logic        rst;
    logic [22:0] memaddr;
    logic [7:0]  memdatao;
    logic        memrd;
    logic        memwr;
    logic        memack;
    logic [7:0]  memdatai;
    logic        err_clr;
    logic        timeout_err;
    logic [19:0] paddr;
    logic        pwrite;
    logic [31:0] pwdata;
    logic        psel;
    logic        penable;
    logic [31:0] prdata;
    logic        pready;

    int   n_cmp;
    int   n_bad;
    logic err_at_ack;

    mcu_apb_bridge dut (
        .cpuclk      (cpuclk),
        .rst         (rst),
        .memaddr     (memaddr),
        .memdatao    (memdatao),
        .memrd       (memrd),
        .memwr       (memwr),
        .memack      (memack),
        .memdatai    (memdatai),
        .err_clr     (err_clr),
        .timeout_err (timeout_err),
        .paddr       (paddr),
        .pwrite      (pwrite),
        .pwdata      (pwdata),
        .psel        (psel),
        .penable     (penable),
        .prdata      (prdata),
        .pready      (pready)
    );

    initial cpuclk = 1'b0;
    always #5 cpuclk = ~cpuclk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [22:0] addr;
        logic [7:0]  wdata;
        logic [31:0] prd;
        int          waits;
        int          hold;
        int          exp_ack;
        int          exp_apb;
        logic        exp_pw;
        logic [19:0] exp_paddr;
        logic [31:0] exp_pwdata;
        logic [7:0]  exp_rdata;
    } vec_t;

    vec_t vecs[14];

    function automatic vec_t mk(input logic rd, input logic wr, input logic [22:0] addr,
                                input logic [7:0] wdata, input logic [31:0] prd, input int waits,
                                input int hold, input int exp_ack, input int exp_apb,
                                input logic exp_pw, input logic [19:0] exp_paddr,
                                input logic [31:0] exp_pwdata, input logic [7:0] exp_rdata);
        vec_t v;
        v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata; v.prd = prd;
        v.waits = waits; v.hold = hold; v.exp_ack = exp_ack; v.exp_apb = exp_apb;
        v.exp_pw = exp_pw; v.exp_paddr = exp_paddr; v.exp_pwdata = exp_pwdata;
        v.exp_rdata = exp_rdata;
        return v;
    endfunction

    task automatic tick();
        @(posedge cpuclk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    // Drives one held MCU request, acts as the APB slave, then releases after v.hold cycles.
    task automatic do_txn(input string nm, input vec_t v, input int clr_at);
        int          ack_c;
        int          apb_n;
        int          acc;
        int          extra;
        int          unstable;
        logic [31:0] cap_wd;
        logic [19:0] cap_pa;
        logic        cap_pw;
        logic [7:0]  rd_b;
        ack_c = -1; apb_n = 0; acc = 0; extra = 0; unstable = 0;
        cap_wd = 32'h0; cap_pa = 20'h0; cap_pw = 1'b0; rd_b = 8'h00;
        err_at_ack = 1'b0;
        memrd = v.rd; memwr = v.wr; memaddr = v.addr; memdatao = v.wdata;
        prdata = v.prd; pready = 1'b0;
        for (int c = 1; c <= BUDGET; c++) begin
            tick();
            err_clr = (c == clr_at);
            if (psel && !penable) begin
                apb_n++;
                cap_wd = pwdata; cap_pa = paddr; cap_pw = pwrite;
            end
            if (penable) begin
                if (!psel || pwdata !== cap_wd || paddr !== cap_pa || pwrite !== cap_pw) unstable++;
                pready = (acc == v.waits);
                acc++;
            end else begin
                pready = 1'b0;
            end
            if (memack) begin
                ack_c = c;
                rd_b = memdatai;
                err_at_ack = timeout_err;
                break;
            end
        end
        pready = 1'b0;
        err_clr = 1'b0;
        for (int h = 0; h < v.hold; h++) begin
            tick();
            if (memack) extra++;
        end
        memrd = 1'b0;
        memwr = 1'b0;
        tick();
        if (memack) extra++;
        chk({nm, " ack_cycle"}, 32'(ack_c), 32'(v.exp_ack));
        chk({nm, " extra_acks"}, 32'(extra), 32'd0);
        chk({nm, " apb_count"}, 32'(apb_n), 32'(v.exp_apb));
        if (v.rd && !v.wr) chk({nm, " memdatai"}, 32'(rd_b), 32'(v.exp_rdata));
        if (v.exp_apb > 0) begin
            chk({nm, " paddr"}, 32'(cap_pa), 32'(v.exp_paddr));
            chk({nm, " pwrite"}, 32'(cap_pw), 32'(v.exp_pw));
            chk({nm, " access_stable"}, 32'(unstable), 32'd0);
            if (v.exp_pw) chk({nm, " pwdata"}, cap_wd, v.exp_pwdata);
        end
    endtask

    initial begin
        vec_t tv;
        n_cmp = 0; n_bad = 0; err_at_ack = 1'b0;
        rst = 1'b1; memaddr = 23'h0; memdatao = 8'h00; memrd = 1'b0; memwr = 1'b0;
        err_clr = 1'b0; prdata = 32'h0; pready = 1'b0;

        //            rd    wr    addr       wd     prdata        waits hold ack apb pw    paddr     pwdata        rdata
        vecs[0]  = mk(1'b0, 1'b1, 23'h20004, 8'h11, 32'h0,        0,    1,   1,  0,  1'b0, 20'h000, 32'h0,        8'h00);
        vecs[1]  = mk(1'b0, 1'b1, 23'h20005, 8'h22, 32'h0,        0,    1,   1,  0,  1'b0, 20'h000, 32'h0,        8'h00);
        vecs[2]  = mk(1'b0, 1'b1, 23'h20006, 8'h33, 32'h0,        0,    1,   1,  0,  1'b0, 20'h000, 32'h0,        8'h00);
        vecs[3]  = mk(1'b0, 1'b1, 23'h20007, 8'h44, 32'h0,        0,    1,   3,  1,  1'b1, 20'h004, 32'h44332211, 8'h00);
        vecs[4]  = mk(1'b1, 1'b0, 23'h20008, 8'h00, 32'hA1B2C3D4, 2,    1,   5,  1,  1'b0, 20'h008, 32'h0,        8'hD4);
        vecs[5]  = mk(1'b1, 1'b0, 23'h20009, 8'h00, 32'h0,        0,    1,   1,  0,  1'b0, 20'h000, 32'h0,        8'hC3);
        vecs[6]  = mk(1'b1, 1'b0, 23'h2000A, 8'h00, 32'h0,        0,    1,   1,  0,  1'b0, 20'h000, 32'h0,        8'hB2);
        vecs[7]  = mk(1'b1, 1'b0, 23'h2000B, 8'h00, 32'h0,        0,    1,   1,  0,  1'b0, 20'h000, 32'h0,        8'hA1);
        vecs[8]  = mk(1'b1, 1'b1, 23'h2000F, 8'h55, 32'h0,        0,    10,  3,  1,  1'b1, 20'h00C, 32'h55332211, 8'h00);
        vecs[9]  = mk(1'b0, 1'b1, 23'h20010, 8'h99, 32'h0,        0,    1,   1,  0,  1'b0, 20'h000, 32'h0,        8'h00);
        vecs[10] = mk(1'b0, 1'b1, 23'h20013, 8'h77, 32'h0,        0,    1,   3,  1,  1'b1, 20'h010, 32'h77332299, 8'h00);
        vecs[11] = mk(1'b0, 1'b1, 23'h20023, 8'h01, 32'h0,        1,    1,   4,  1,  1'b1, 20'h020, 32'h01332299, 8'h00);
        vecs[12] = mk(1'b0, 1'b1, 23'h20027, 8'h02, 32'h0,        0,    1,   3,  1,  1'b1, 20'h024, 32'h02332299, 8'h00);
        vecs[13] = mk(1'b1, 1'b0, 23'h20102, 8'h00, 32'h0,        0,    1,   1,  0,  1'b0, 20'h000, 32'h0,        8'hB2);

        // Reset state
        tick();
        tick();
        chk("rst memack", 32'(memack), 32'd0);
        chk("rst psel", 32'(psel), 32'd0);
        chk("rst penable", 32'(penable), 32'd0);
        chk("rst pwrite", 32'(pwrite), 32'd0);
        chk("rst timeout_err", 32'(timeout_err), 32'd0);
        chk("rst memdatai", 32'(memdatai), 32'd0);
        chk("rst paddr", 32'(paddr), 32'd0);
        chk("rst pwdata", pwdata, 32'd0);
        rst = 1'b0;
        tick();

        // Table: byte gather, word fetch, lane shadows, rd+wr priority, merge, back-to-back writes
        for (int i = 0; i < 14; i++) do_txn($sformatf("vec%0d", i), vecs[i], -1);

        // Timeout with no clear pending
        tv = mk(1'b1, 1'b0, 23'h20040, 8'h00, 32'h12345678, 100000, 1, 258, 1, 1'b0, 20'h040, 32'h0, 8'hFF);
        do_txn("timeout", tv, -1);
        chk("timeout err_at_ack", 32'(err_at_ack), 32'd1);
        chk("timeout err sticky", 32'(timeout_err), 32'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("err_clr clears", 32'(timeout_err), 32'd0);
        tv = mk(1'b1, 1'b0, 23'h20043, 8'h00, 32'h0, 0, 1, 1, 0, 1'b0, 20'h000, 32'h0, 8'hFF);
        do_txn("rshadow after timeout", tv, -1);

        // Timeout coinciding with err_clr: set wins
        tv = mk(1'b1, 1'b0, 23'h20044, 8'h00, 32'h0, 100000, 1, 258, 1, 1'b0, 20'h044, 32'h0, 8'hFF);
        do_txn("timeout+clr", tv, 257);
        chk("timeout+clr err_at_ack", 32'(err_at_ack), 32'd1);

        // Reset in the middle of an APB access
        memrd = 1'b1; memaddr = 23'h20000; pready = 1'b0;
        tick();
        tick();
        chk("pre-rst penable", 32'(penable & psel), 32'd1);
        rst = 1'b1;
        memrd = 1'b0;
        tick();
        chk("mid-rst psel", 32'(psel), 32'd0);
        chk("mid-rst penable", 32'(penable), 32'd0);
        chk("mid-rst memack", 32'(memack), 32'd0);
        chk("mid-rst timeout_err", 32'(timeout_err), 32'd0);
        chk("mid-rst paddr", 32'(paddr), 32'd0);
        rst = 1'b0;
        tick();
        tv = mk(1'b1, 1'b0, 23'h20001, 8'h00, 32'h0, 0, 1, 1, 0, 1'b0, 20'h000, 32'h0, 8'h00);
        do_txn("post-rst rshadow", tv, -1);
        tv = mk(1'b0, 1'b1, 23'h20003, 8'hAB, 32'h0, 0, 1, 3, 1, 1'b1, 20'h000, 32'hAB000000, 8'h00);
        do_txn("post-rst wshadow", tv, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
